// File: rtl/regfile_wb_initiator.sv
// rtl/regfile_wb_initiator.sv - writeback request FIFO draining into the register file write port
// Also flags read-after-write hazards for reads issued while a write is still pending.
module regfile_wb_initiator #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_rd,
  input  logic [DW-1:0]            req_data,
  input  logic                     flush,
  output logic [AW-1:0]            rf_write_register,
  output logic                     rf_WEn,
  output logic [DW-1:0]            rf_Write_data,
  input  logic [AW-1:0]            chk_reg1,
  input  logic [AW-1:0]            chk_reg2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fifo_rd   [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic accept;
  logic push;
  logic pop;

  assign count     = count_q;
  assign req_ready = (count_q < CW'(DEPTH));
  assign accept    = req_valid && req_ready && !flush;
  // Writes to x0 are consumed by the handshake but never queued.
  assign push      = accept && (req_rd != '0);
  assign pop       = (count_q != '0) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count_q           <= '0;
      rf_WEn            <= 1'b0;
      rf_write_register <= '0;
      rf_Write_data     <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rf_WEn  <= 1'b0;
    end else begin
      rf_WEn <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr            <= rd_ptr + 1'b1;
        rf_write_register <= fifo_rd[rd_ptr];
        rf_Write_data     <= fifo_data[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: only slots covered by count are ever read out or matched.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= req_rd;
      fifo_data[wr_ptr] <= req_data;
    end
  end

  logic [DEPTH-1:0] entry_valid;
  logic             match1;
  logic             match2;

  // A slot is live when it lies within count positions of the read pointer.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        entry_valid[rd_ptr + PW'(i)] = 1'b1;
      end
    end
  end

  // The output stage counts as pending: the register file commits at the end of the rf_WEn cycle.
  always_comb begin
    match1 = rf_WEn && (rf_write_register == chk_reg1);
    match2 = rf_WEn && (rf_write_register == chk_reg2);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (fifo_rd[i] == chk_reg1)) begin
        match1 = 1'b1;
      end
      if (entry_valid[i] && (fifo_rd[i] == chk_reg2)) begin
        match2 = 1'b1;
      end
    end
  end

  assign hazard1 = match1 && (chk_reg1 != '0);
  assign hazard2 = match2 && (chk_reg2 != '0);

endmodule
